// File: rtl/cmp_result_debouncer_pkg.sv
// Shared result-code constants, FSM state encoding and flag helper for the
// comparator result debouncer.
package cmp_result_debouncer_pkg;

    localparam logic [1:0] CODE_NONE = 2'b00;
    localparam logic [1:0] CODE_GT   = 2'b01;
    localparam logic [1:0] CODE_EQ   = 2'b10;
    localparam logic [1:0] CODE_LT   = 2'b11;

    typedef enum logic [1:0] {
        ST_UNLOCKED  = 2'b00,
        ST_LOCKED    = 2'b01,
        ST_CANDIDATE = 2'b10
    } dbnc_state_e;

    function automatic logic is_one_hot3(input logic [2:0] flags);
        return (flags == 3'b001) || (flags == 3'b010) || (flags == 3'b100);
    endfunction

endpackage

// File: rtl/cmp_flag_encode.sv
// Maps the comparator gt/eq/lt flags onto a 2-bit result code and reports
// whether exactly one flag is set.
module cmp_flag_encode
    import cmp_result_debouncer_pkg::*;
(
    input  logic       gt,
    input  logic       eq,
    input  logic       lt,
    output logic [1:0] code,
    output logic       one_hot
);

    // Flag-to-code mapping; anything not one-hot yields CODE_NONE.
    always_comb begin
        code    = CODE_NONE;
        one_hot = is_one_hot3({gt, eq, lt});
        case ({gt, eq, lt})
            3'b100:  code = CODE_GT;
            3'b010:  code = CODE_EQ;
            3'b001:  code = CODE_LT;
            default: code = CODE_NONE;
        endcase
    end

endmodule

// File: rtl/cmp_result_debouncer.sv
// Debounces a comparator result stream: a code must repeat DEBOUNCE_LEN
// accepted samples in a row before it becomes the stable result.
module cmp_result_debouncer
    import cmp_result_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_LEN = 4,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             gt,
    input  logic             eq,
    input  logic             lt,
    input  logic             clr,
    output logic             stable_valid,
    output logic [1:0]       stable_code,
    output logic             evt_valid,
    output logic [1:0]       evt_code,
    input  logic             evt_ready,
    output logic [CNT_W-1:0] chg_cnt,
    output logic             err,
    output logic             ovf
);

    localparam logic [3:0]       LEN     = 4'(DEBOUNCE_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    dbnc_state_e      state_q, state_d;
    logic [1:0]       cand_q, cand_d;
    logic [3:0]       run_cnt_q, run_cnt_d;
    logic             stable_valid_q, stable_valid_d;
    logic [1:0]       stable_code_q, stable_code_d;
    logic             evt_valid_q, evt_valid_d;
    logic [1:0]       evt_code_q, evt_code_d;
    logic [CNT_W-1:0] chg_cnt_q, chg_cnt_d;
    logic             err_q, err_d;
    logic             ovf_q, ovf_d;

    logic [1:0] code_s;
    logic       one_hot_s;
    logic       accept_s;
    logic       bad_s;
    logic       raise_s;
    logic       count_chg_s;
    logic [3:0] run_inc_s;

    cmp_flag_encode u_enc (
        .gt      (gt),
        .eq      (eq),
        .lt      (lt),
        .code    (code_s),
        .one_hot (one_hot_s)
    );

    assign accept_s  = in_valid & one_hot_s;
    assign bad_s     = in_valid & ~one_hot_s;
    assign run_inc_s = run_cnt_q + 4'd1;

    // Debounce FSM: run tracking, locking and stable-result updates.
    always_comb begin
        state_d        = state_q;
        cand_d         = cand_q;
        run_cnt_d      = run_cnt_q;
        stable_valid_d = stable_valid_q;
        stable_code_d  = stable_code_q;
        raise_s        = 1'b0;
        count_chg_s    = 1'b0;
        case (state_q)
            ST_UNLOCKED: begin
                if (accept_s) begin
                    if (code_s == cand_q) begin
                        if (run_inc_s == LEN) begin
                            state_d        = ST_LOCKED;
                            stable_valid_d = 1'b1;
                            stable_code_d  = cand_q;
                            run_cnt_d      = 4'd0;
                            raise_s        = 1'b1;
                        end else begin
                            run_cnt_d = run_inc_s;
                        end
                    end else begin
                        cand_d    = code_s;
                        run_cnt_d = 4'd1;
                    end
                end else begin
                    state_d = ST_UNLOCKED;
                end
            end
            ST_LOCKED: begin
                if (accept_s && (code_s != stable_code_q)) begin
                    state_d   = ST_CANDIDATE;
                    cand_d    = code_s;
                    run_cnt_d = 4'd1;
                end else begin
                    state_d = ST_LOCKED;
                end
            end
            ST_CANDIDATE: begin
                if (accept_s) begin
                    if (code_s == cand_q) begin
                        if (run_inc_s == LEN) begin
                            state_d       = ST_LOCKED;
                            stable_code_d = cand_q;
                            run_cnt_d     = 4'd0;
                            raise_s       = 1'b1;
                            count_chg_s   = 1'b1;
                        end else begin
                            run_cnt_d = run_inc_s;
                        end
                    end else if (code_s == stable_code_q) begin
                        state_d   = ST_LOCKED;
                        run_cnt_d = 4'd0;
                    end else begin
                        cand_d    = code_s;
                        run_cnt_d = 4'd1;
                    end
                end else begin
                    state_d = ST_CANDIDATE;
                end
            end
            default: begin
                state_d   = ST_UNLOCKED;
                cand_d    = CODE_NONE;
                run_cnt_d = 4'd0;
            end
        endcase
    end

    // Event handshake, change counter and sticky flags; clr has priority.
    always_comb begin
        evt_valid_d = evt_valid_q;
        evt_code_d  = evt_code_q;
        chg_cnt_d   = chg_cnt_q;
        err_d       = err_q;
        ovf_d       = ovf_q;
        if (raise_s) begin
            evt_valid_d = 1'b1;
            evt_code_d  = stable_code_d;
            if (evt_valid_q && !evt_ready) begin
                ovf_d = 1'b1;
            end else begin
                ovf_d = ovf_q;
            end
        end else if (evt_valid_q && evt_ready) begin
            evt_valid_d = 1'b0;
        end else begin
            evt_valid_d = evt_valid_q;
        end
        if (count_chg_s && (chg_cnt_q != CNT_MAX)) begin
            chg_cnt_d = chg_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            chg_cnt_d = chg_cnt_q;
        end
        if (bad_s) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
        if (clr) begin
            chg_cnt_d = {CNT_W{1'b0}};
            err_d     = 1'b0;
            ovf_d     = 1'b0;
        end else begin
            chg_cnt_d = chg_cnt_d;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_UNLOCKED;
            cand_q         <= CODE_NONE;
            run_cnt_q      <= 4'd0;
            stable_valid_q <= 1'b0;
            stable_code_q  <= CODE_NONE;
            evt_valid_q    <= 1'b0;
            evt_code_q     <= CODE_NONE;
            chg_cnt_q      <= {CNT_W{1'b0}};
            err_q          <= 1'b0;
            ovf_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            cand_q         <= cand_d;
            run_cnt_q      <= run_cnt_d;
            stable_valid_q <= stable_valid_d;
            stable_code_q  <= stable_code_d;
            evt_valid_q    <= evt_valid_d;
            evt_code_q     <= evt_code_d;
            chg_cnt_q      <= chg_cnt_d;
            err_q          <= err_d;
            ovf_q          <= ovf_d;
        end
    end

    assign stable_valid = stable_valid_q;
    assign stable_code  = stable_code_q;
    assign evt_valid    = evt_valid_q;
    assign evt_code     = evt_code_q;
    assign chg_cnt      = chg_cnt_q;
    assign err          = err_q;
    assign ovf          = ovf_q;

endmodule

// File: tb/tb_cmp_result_debouncer.sv
// Randomized and directed bench for cmp_result_debouncer against a
// history-window reference model.
module tb_cmp_result_debouncer;

    localparam int N     = 4;
    localparam int CMAX  = 255;
    localparam logic [2:0] F_GT   = 3'b100;
    localparam logic [2:0] F_EQ   = 3'b010;
    localparam logic [2:0] F_LT   = 3'b001;
    localparam logic [2:0] F_NONE = 3'b000;

    logic       clk = 1'b0;
    logic       rst, in_valid, gt, eq, lt, clr, evt_ready;
    logic       stable_valid, evt_valid, err, ovf;
    logic [1:0] stable_code, evt_code;
    logic [7:0] chg_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: recent accepted codes plus the observable outputs.
    int hist[$];
    int m_sv, m_sc, m_ev, m_ec, m_chg, m_err, m_ovf;

    cmp_result_debouncer #(.DEBOUNCE_LEN(N), .CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .gt           (gt),
        .eq           (eq),
        .lt           (lt),
        .clr          (clr),
        .stable_valid (stable_valid),
        .stable_code  (stable_code),
        .evt_valid    (evt_valid),
        .evt_code     (evt_code),
        .evt_ready    (evt_ready),
        .chg_cnt      (chg_cnt),
        .err          (err),
        .ovf          (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        hist.delete();
        m_sv = 0; m_sc = 0; m_ev = 0; m_ec = 0; m_chg = 0; m_err = 0; m_ovf = 0;
    endtask

    // A code locks once the last N accepted samples all equal it and it is
    // not already the stable result.
    task automatic model_step(input logic v, input logic [2:0] f, input logic r, input logic c);
        int  code;
        bit  raise;
        bit  same;
        raise = 0;
        code  = 0;
        if (v && $countones(f) != 1) m_err = 1;
        if (v && $countones(f) == 1) begin
            code = f[2] ? 1 : (f[1] ? 2 : 3);
            hist.push_back(code);
            if (hist.size() > N) void'(hist.pop_front());
            same = (hist.size() == N);
            foreach (hist[i]) if (hist[i] != code) same = 0;
            if (same && (!m_sv || code != m_sc)) begin
                raise = 1;
                if (m_sv && m_chg < CMAX) m_chg++;
                m_sv = 1;
                m_sc = code;
            end
        end
        if (raise) begin
            if (m_ev && !r) m_ovf = 1;
            m_ev = 1;
            m_ec = code;
        end else if (m_ev && r) begin
            m_ev = 0;
        end
        if (c) begin
            m_chg = 0; m_err = 0; m_ovf = 0;
        end
    endtask

    task automatic compare_all();
        chk("stable_valid", 32'(stable_valid), 32'(m_sv));
        chk("stable_code",  32'(stable_code),  32'(m_sc));
        chk("evt_valid",    32'(evt_valid),    32'(m_ev));
        if (m_ev != 0) chk("evt_code", 32'(evt_code), 32'(m_ec));
        chk("chg_cnt",      32'(chg_cnt),      32'(m_chg));
        chk("err",          32'(err),          32'(m_err));
        chk("ovf",          32'(ovf),          32'(m_ovf));
    endtask

    task automatic step(input logic v, input logic [2:0] f, input logic r, input logic c);
        in_valid = v; {gt, eq, lt} = f; evt_ready = r; clr = c;
        @(posedge clk);
        model_step(v, f, r, c);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0; {gt, eq, lt} = F_NONE; evt_ready = 1'b0; clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        compare_all();
    endtask

    initial begin
        logic [2:0] f;
        logic [2:0] prev;
        model_reset();
        do_reset();

        // First lock of GT after four samples, no change counted.
        repeat (N - 1) step(1'b1, F_GT, 1'b0, 1'b0);
        chk("pre_lock_valid", 32'(stable_valid), 32'd0);
        step(1'b1, F_GT, 1'b0, 1'b0);
        chk("lock_gt_code", 32'(stable_code), 32'd1);
        chk("lock_gt_evt", 32'(evt_valid), 32'd1);
        chk("lock_gt_chg", 32'(chg_cnt), 32'd0);

        // Interrupted LT run, then a full LT run changes the result.
        step(1'b1, F_LT, 1'b1, 1'b0);
        step(1'b1, F_LT, 1'b1, 1'b0);
        step(1'b1, F_GT, 1'b1, 1'b0);
        repeat (3) step(1'b1, F_LT, 1'b1, 1'b0);
        chk("hold_gt_code", 32'(stable_code), 32'd1);
        step(1'b1, F_LT, 1'b1, 1'b0);
        chk("change_lt_code", 32'(stable_code), 32'd3);
        chk("change_lt_chg", 32'(chg_cnt), 32'd1);

        // Gaps and a bad sample around a locked EQ.
        do_reset();
        repeat (N) step(1'b1, F_EQ, 1'b1, 1'b0);
        step(1'b1, F_EQ, 1'b1, 1'b0);
        step(1'b0, F_GT, 1'b1, 1'b0);
        step(1'b1, F_EQ, 1'b1, 1'b0);
        step(1'b1, 3'b110, 1'b1, 1'b0);
        chk("bad_err", 32'(err), 32'd1);
        chk("bad_code", 32'(stable_code), 32'd2);
        // A bad sample and a gap inside a candidate run do not break it.
        step(1'b1, F_GT, 1'b1, 1'b0);
        step(1'b1, 3'b111, 1'b1, 1'b0);
        step(1'b1, F_GT, 1'b1, 1'b0);
        step(1'b0, F_NONE, 1'b1, 1'b0);
        step(1'b1, F_GT, 1'b1, 1'b0);
        step(1'b1, F_GT, 1'b1, 1'b0);
        chk("gap_run_code", 32'(stable_code), 32'd1);

        // Drive the change counter to saturation and beyond.
        for (int k = 0; k < 260; k++) begin
            f = k[0] ? F_GT : F_EQ;
            repeat (N) step(1'b1, f, 1'b1, 1'b0);
        end
        chk("sat_chg", 32'(chg_cnt), 32'd255);
        repeat (N - 1) step(1'b1, F_LT, 1'b1, 1'b0);
        step(1'b1, F_LT, 1'b1, 1'b1);
        chk("clr_wins_chg", 32'(chg_cnt), 32'd0);
        chk("clr_wins_code", 32'(stable_code), 32'd3);

        // Overwrite of an unaccepted event.
        do_reset();
        repeat (N) step(1'b1, F_GT, 1'b0, 1'b0);
        repeat (N) step(1'b1, F_LT, 1'b0, 1'b0);
        chk("ovf_code", 32'(evt_code), 32'd3);
        chk("ovf_flag", 32'(ovf), 32'd1);
        step(1'b0, F_NONE, 1'b1, 1'b0);
        chk("ovf_drain", 32'(evt_valid), 32'd0);

        // Asynchronous reset mid-candidate with a pending event.
        repeat (N) step(1'b1, F_GT, 1'b0, 1'b0);
        step(1'b1, F_LT, 1'b0, 1'b0);
        step(1'b1, F_LT, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        model_reset();
        chk("arst_sv", 32'(stable_valid), 32'd0);
        chk("arst_sc", 32'(stable_code), 32'd0);
        chk("arst_ev", 32'(evt_valid), 32'd0);
        chk("arst_ec", 32'(evt_code), 32'd0);
        chk("arst_ovf", 32'(ovf), 32'd0);
        compare_all();
        #2;
        rst = 1'b0;
        repeat (N - 1) step(1'b1, F_LT, 1'b1, 1'b0);
        chk("post_rst_nolock", 32'(stable_valid), 32'd0);

        // Random traffic biased toward repeated codes.
        prev = F_GT;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) == 0) f = 3'($urandom_range(0, 7));
            else if ($urandom_range(0, 9) < 7) f = prev;
            else begin
                case ($urandom_range(0, 2))
                    0:       f = F_GT;
                    1:       f = F_EQ;
                    default: f = F_LT;
                endcase
            end
            if ($countones(f) == 1) prev = f;
            step(($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0, f,
                 1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cmp_result_debouncer.md
CMP_RESULT_DEBOUNCER -- requirements
Module: cmp_result_debouncer

Interface
REQ-001 Parameter DEBOUNCE_LEN, default 4, consecutive identical samples needed to lock a result; legal range 2..15.
REQ-002 Parameter CNT_W, default 8, width of change counter.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 in_valid  in  1  gt/eq/lt sample qualifier.
REQ-006 gt  in  1  upstream comparator flag A>B.
REQ-007 eq  in  1  upstream comparator flag A==B.
REQ-008 lt  in  1  upstream comparator flag A<B.
REQ-009 clr  in  1  synchronous clear of chg_cnt, err, ovf.
REQ-010 stable_valid  out  1  a debounced result has been locked.
REQ-011 stable_code  out  2  locked result: 01 GT, 10 EQ, 11 LT, 00 none.
REQ-012 evt_valid  out  1  lock/change event pending.
REQ-013 evt_code  out  2  code of pending event, same encoding as stable_code.
REQ-014 evt_ready  in  1  consumer accepts event when evt_valid and evt_ready both high at an edge.
REQ-015 chg_cnt  out  CNT_W  number of stable-result changes, saturating.
REQ-016 err  out  1  sticky: non-one-hot sample seen.
REQ-017 ovf  out  1  sticky: event lost to overwrite.

Function
REQ-018 Sample accepted when in_valid=1 and exactly one of gt/eq/lt is 1; code mapped per REQ-011.
REQ-019 in_valid=1 with zero or multiple flags set shall set err, be otherwise ignored, and not break a run.
REQ-020 in_valid=0 cycles shall hold all state; they neither extend nor break a run.
REQ-021 FSM states UNLOCKED, LOCKED, CANDIDATE; internal cand (2 bits) and run_cnt (4 bits).
REQ-022 UNLOCKED: accepted code==cand -> run_cnt+1; else cand=code, run_cnt=1; when run_cnt reaches DEBOUNCE_LEN -> LOCKED, stable_code=cand, stable_valid=1, event raised, chg_cnt unchanged.
REQ-023 LOCKED: accepted code==stable_code -> stay; different -> CANDIDATE, cand=code, run_cnt=1.
REQ-024 CANDIDATE: code==cand -> run_cnt+1, on reaching DEBOUNCE_LEN -> LOCKED, stable_code=cand, event raised, chg_cnt+1; code==stable_code -> LOCKED; other code -> cand=code, run_cnt=1.
REQ-025 Latency: stable_code/evt_valid change at the edge accepting the DEBOUNCE_LEN-th consecutive sample, visible next cycle.
REQ-026 Event raise sets evt_valid=1, evt_code=new stable_code.
REQ-027 evt_valid clears on acceptance unless a new event is raised the same edge, then stays 1 with new code, no ovf.
REQ-028 Event raised while evt_valid=1 and evt_ready=0: evt_code overwritten with newest, ovf set.
REQ-029 chg_cnt saturates at 2^CNT_W-1.
REQ-030 clr clears chg_cnt, err, ovf; clr wins over same-edge increment/set; FSM, stable and event state unaffected.

Reset
REQ-031 rst asserted: FSM=UNLOCKED, cand=00, run_cnt=0, stable_valid=0, stable_code=00, evt_valid=0, evt_code=00, chg_cnt=0, err=0, ovf=0, immediately without clock.
REQ-032 Reset mid-run or with pending event discards all; first edge after deassertion is a normal sample cycle.

Structure
REQ-033 Shared package holds 2-bit result-code constants (NONE, GT, EQ, LT) and FSM state encodings.
REQ-034 Single flat module; flag-to-code encoder with one-hot check as optional sub-module cmp_flag_encode.

Verification
REQ-035 Reset, then 4x GT valid -> stable_code=01, stable_valid=1, evt_valid=1 one cycle after 4th sample, chg_cnt=0.
REQ-036 Locked GT, then LT,LT,GT,LT,LT,LT,LT -> stays 01 until 4th consecutive LT, then 11, chg_cnt=1.
REQ-037 Locked EQ, samples EQ,EQ with in_valid=0 gaps and gt=eq=1 sample -> err=1, stable_code=10 unchanged.
REQ-038 evt_ready=0, lock GT then change to LT -> evt_code=11, ovf=1; evt_ready=1 one cycle -> evt_valid=0.
REQ-039 chg_cnt at 255 (CNT_W=8) plus one change -> 255; clr with same-edge change -> chg_cnt=0.
REQ-040 rst asserted mid-candidate run with evt_valid=1 -> all outputs 0 asynchronously; next 3 samples do not lock.
